turbo_itl_sched: RTL and testbench
==================================

TURBO_ITL_SCHED -- requirements
Module: turbo_itl_sched

Interface
REQ-001 SHALL have parameter A_WIDTH, default 12, width of PB length/address fields.
REQ-002 SHALL have parameter DRAIN, default 2, post-read pipeline drain cycles (interleaver RAM + output mux latency).
REQ-003 SHALL have ports: clk input 1, clock; n_rst input 1, reset, asynchronous, active-low.
REQ-004 SHALL have cfg_pb_len input A_WIDTH, PB length for the next job (legal: 0x040, 0x220, 0x820).
REQ-005 SHALL have req_int input 1, interleave request, level held until done.
REQ-006 SHALL have req_dint input 1, deinterleave request, level held until done.
REQ-007 SHALL have abort input 1, synchronous job cancel.
REQ-008 SHALL have gnt_int output 1 and gnt_dint output 1, one-hot grant for the current job.
REQ-009 SHALL have itl_start output 1, one-cycle start pulse to the interleaver read engine.
REQ-010 SHALL have itl_mod output 1 (0 = interleave, 1 = deinterleave), itl_pb_len output A_WIDTH, itl_din_vld output 1.
REQ-011 SHALL have busy output 1, done output 1 (pulse), err output 1 (pulse, with done), job_cnt output 8.

Function
REQ-012 SHALL implement states IDLE, START, RUN, DRAIN, DONE.
REQ-013 IDLE: with req_int or req_dint high, SHALL select a winner round-robin (winner = requester not granted last; single requester wins directly).
REQ-014 On selection, SHALL latch cfg_pb_len into itl_pb_len and winner into itl_mod; later cfg_pb_len changes SHALL not affect the running job.
REQ-015 Legal length: next state START. Illegal length: next state DONE with err=1, no itl_start, no itl_din_vld.
REQ-016 START lasts 1 cycle: itl_start=1, itl_din_vld=1; next RUN.
REQ-017 RUN SHALL last exactly Q = itl_pb_len>>2 cycles (16/136/520), with itl_din_vld=1 and a down-counter of A_WIDTH-2 bits; next DRAIN.
REQ-018 DRAIN SHALL last exactly DRAIN cycles with itl_din_vld=0; next DONE.
REQ-019 DONE lasts 1 cycle: done=1; next IDLE; job_cnt increments (wraps 0xFF->0x00) for legal and illegal jobs.
REQ-020 The grant SHALL be asserted from START through DONE inclusive (DONE only for illegal jobs); gnt_int/gnt_dint never both high.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 The round-robin pointer SHALL update on entry to DONE only; aborted jobs SHALL not update it.
REQ-023 abort in START/RUN/DRAIN SHALL force IDLE next cycle, drop grant and itl_din_vld, no done, no job_cnt change; abort in IDLE/DONE SHALL be ignored.
REQ-024 A request dropped before done SHALL not cancel the job; the job completes normally.
REQ-025 Requests seen in the DONE cycle SHALL not be arbitrated until IDLE (one idle cycle minimum between jobs).

Reset
REQ-026 On n_rst low, SHALL asynchronously enter IDLE; all outputs 0 (gnt_*, itl_start, itl_mod, itl_din_vld, busy, done, err, itl_pb_len, job_cnt); pointer set so req_int wins the first tie.
REQ-027 Reset asserted mid-job SHALL abandon the job with no done pulse.

Verification
REQ-028 req_int, cfg_pb_len=0x040, itl_start at cycle t -> itl_din_vld t..t+16 (17 cycles), done at t+19, itl_mod=0, job_cnt=1.
REQ-029 req_dint, cfg_pb_len=0x820 -> itl_mod=1, RUN 520 cycles, done at t+523; with 0x220 done at t+139.
REQ-030 req_int and req_dint both held -> grants alternate int, dint, int across three jobs, one IDLE cycle between.
REQ-031 cfg_pb_len=0x100 with req_int -> no itl_start, done=err=1 two cycles after request, job_cnt increments.
REQ-032 abort at RUN cycle 50 of a 0x220 job -> IDLE next cycle, no done, job_cnt unchanged; pending req_dint then granted.
REQ-033 n_rst low during RUN -> all outputs 0 immediately; after release, req_int wins a tie.

Source files
------------

// File: rtl/turbo_itl_sched.sv
// Turbo interleaver job scheduler: round-robin arbitration between interleave
// and deinterleave requesters, sequencing START/RUN/DRAIN/DONE for each job.
module turbo_itl_sched #(
  parameter int A_WIDTH = 12,
  parameter int DRAIN   = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [A_WIDTH-1:0] cfg_pb_len,
  input  logic               req_int,
  input  logic               req_dint,
  input  logic               abort,
  output logic               gnt_int,
  output logic               gnt_dint,
  output logic               itl_start,
  output logic               itl_mod,
  output logic [A_WIDTH-1:0] itl_pb_len,
  output logic               itl_din_vld,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [7:0]         job_cnt
);

  localparam int CW = A_WIDTH - 2;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mod_q, mod_d;
  logic [A_WIDTH-1:0] len_q, len_d;
  logic               err_q, err_d;
  logic               last_q, last_d;   // 1 = deinterleave was granted last
  logic [7:0]         job_cnt_q, job_cnt_d;

  logic winner;
  logic len_legal;

  assign winner    = (req_int && req_dint) ? ~last_q : req_dint;
  assign len_legal = (cfg_pb_len == A_WIDTH'(12'h040)) ||
                     (cfg_pb_len == A_WIDTH'(12'h220)) ||
                     (cfg_pb_len == A_WIDTH'(12'h820));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mod_q     <= 1'b0;
      len_q     <= '0;
      err_q     <= 1'b0;
      last_q    <= 1'b1;
      job_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mod_q     <= mod_d;
      len_q     <= len_d;
      err_q     <= err_d;
      last_q    <= last_d;
      job_cnt_q <= job_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mod_d     = mod_q;
    len_d     = len_q;
    err_d     = err_q;
    last_d    = last_q;
    job_cnt_d = job_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_int || req_dint) begin
          mod_d = winner;
          len_d = cfg_pb_len;
          if (len_legal) begin
            state_d = S_START;
            err_d   = 1'b0;
          end else begin
            state_d   = S_DONE;
            err_d     = 1'b1;
            last_d    = winner;
            job_cnt_d = job_cnt_q + 8'd1;
          end
        end
      end
      S_START: begin
        cnt_d   = len_q[A_WIDTH-1:2] - CW'(1);
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          if (DRAIN == 0) begin
            state_d   = S_DONE;
            last_d    = mod_q;
            job_cnt_d = job_cnt_q + 8'd1;
          end else begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          last_d    = mod_q;
          job_cnt_d = job_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any transition into DONE, so pointer and count stay put.
    if (abort && (state_q == S_START || state_q == S_RUN || state_q == S_DRAIN)) begin
      state_d   = S_IDLE;
      last_d    = last_q;
      job_cnt_d = job_cnt_q;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign gnt_int     = busy && !mod_q;
  assign gnt_dint    = busy && mod_q;
  assign itl_start   = (state_q == S_START);
  assign itl_din_vld = (state_q == S_START) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign err         = (state_q == S_DONE) && err_q;
  assign itl_mod     = mod_q;
  assign itl_pb_len  = len_q;
  assign job_cnt     = job_cnt_q;

endmodule

// File: tb/tb_turbo_itl_sched.sv
// Directed bench for turbo_itl_sched: job timing, arbitration, illegal length,
// abort and mid-job reset.
module tb_turbo_itl_sched;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [11:0] cfg_pb_len;
  logic        req_int, req_dint, abort;
  logic        gnt_int, gnt_dint, itl_start, itl_mod, itl_din_vld;
  logic        busy, done, err;
  logic [11:0] itl_pb_len;
  logic [7:0]  job_cnt;

  int checks = 0;
  int errors = 0;

  int  off, vld, ok;
  logic both_seen;
  logic start_seen;

  turbo_itl_sched #(.A_WIDTH(12), .DRAIN(2)) dut (
    .clk(clk), .n_rst(n_rst), .cfg_pb_len(cfg_pb_len),
    .req_int(req_int), .req_dint(req_dint), .abort(abort),
    .gnt_int(gnt_int), .gnt_dint(gnt_dint), .itl_start(itl_start),
    .itl_mod(itl_mod), .itl_pb_len(itl_pb_len), .itl_din_vld(itl_din_vld),
    .busy(busy), .done(done), .err(err), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for itl_start; ok=1 when seen.
  task automatic wait_start(output int ok_o);
    ok_o = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (itl_start) begin
        ok_o = 1;
        break;
      end
    end
  endtask

  // From the START cycle: offset of done, number of din_vld cycles.
  task automatic measure(output int off_o, output int vld_o, output logic both_o);
    off_o  = 0;
    vld_o  = 0;
    both_o = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (itl_din_vld) vld_o++;
      if (gnt_int && gnt_dint) both_o = 1'b1;
      if (done) break;
      tick();
      off_o++;
    end
  endtask

  initial begin
    n_rst = 1'b1; cfg_pb_len = 12'h040; req_int = 1'b0; req_dint = 1'b0; abort = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_gnt", {gnt_int, gnt_dint}, 0);
    check("rst_outs", {itl_start, itl_mod, itl_din_vld, done, err}, 0);
    check("rst_len", itl_pb_len, 0);
    check("rst_jobcnt", job_cnt, 0);
    tick();
    n_rst = 1'b1;
    tick();

    // Interleave, 0x040; length change after selection must not leak in.
    req_int = 1'b1;
    wait_start(ok);
    check("j1_start", ok, 1);
    cfg_pb_len = 12'h100;
    check("j1_gnt", {gnt_int, gnt_dint}, 2'b10);
    measure(off, vld, both_seen);
    check("j1_done_off", off, 19);
    check("j1_vld_cnt", vld, 17);
    check("j1_mod", itl_mod, 0);
    check("j1_len", itl_pb_len, 12'h040);
    check("j1_jobcnt", job_cnt, 1);
    check("j1_err", err, 0);
    check("j1_gnt_done", gnt_int, 1);
    req_int = 1'b0;
    tick();
    check("j1_idle", busy, 0);

    // Deinterleave, 0x820 then 0x220.
    cfg_pb_len = 12'h820; req_dint = 1'b1;
    wait_start(ok);
    check("j2_start", ok, 1);
    measure(off, vld, both_seen);
    check("j2_done_off", off, 523);
    check("j2_vld_cnt", vld, 521);
    check("j2_mod", itl_mod, 1);
    check("j2_gnt", {gnt_int, gnt_dint}, 2'b01);
    check("j2_jobcnt", job_cnt, 2);
    req_dint = 1'b0;
    tick();
    cfg_pb_len = 12'h220; req_dint = 1'b1;
    wait_start(ok);
    check("j3_start", ok, 1);
    measure(off, vld, both_seen);
    check("j3_done_off", off, 139);
    check("j3_jobcnt", job_cnt, 3);
    req_dint = 1'b0;
    tick();

    // Both held: int, dint, int with an idle cycle between jobs.
    cfg_pb_len = 12'h040; req_int = 1'b1; req_dint = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_start(ok);
      check("rr_start", ok, 1);
      check("rr_mod", itl_mod, (j == 1) ? 1 : 0);
      measure(off, vld, both_seen);
      check("rr_done_off", off, 19);
      check("rr_onehot", both_seen, 0);
      if (j == 2) begin
        req_int = 1'b0; req_dint = 1'b0;
      end
      tick();
      check("rr_gap_idle", busy, 0);
    end
    check("rr_jobcnt", job_cnt, 6);

    // Illegal length: done with err, never starts.
    cfg_pb_len = 12'h100; req_int = 1'b1;
    start_seen = 1'b0; ok = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (itl_start || itl_din_vld) start_seen = 1'b1;
      if (done) begin
        ok = 1;
        break;
      end
    end
    check("ill_done", ok, 1);
    check("ill_err", err, 1);
    check("ill_nostart", start_seen, 0);
    check("ill_gnt", {gnt_int, gnt_dint}, 2'b10);
    check("ill_jobcnt", job_cnt, 7);
    req_int = 1'b0;
    tick();
    check("ill_idle", busy, 0);

    // Abort at RUN cycle 50 of a 0x220 job, dint pending.
    cfg_pb_len = 12'h220; req_int = 1'b1;
    wait_start(ok);
    check("ab_start", ok, 1);
    req_dint = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    check("ab_running", {busy, itl_din_vld, gnt_int}, 3'b111);
    abort = 1'b1;
    tick();
    abort = 1'b0; req_int = 1'b0;
    check("ab_idle", busy, 0);
    check("ab_gnt", {gnt_int, gnt_dint}, 0);
    check("ab_vld_done", {itl_din_vld, done}, 0);
    check("ab_jobcnt", job_cnt, 7);
    tick();
    check("ab_dint_start", itl_start, 1);
    check("ab_dint_mod", itl_mod, 1);
    measure(off, vld, both_seen);
    check("ab_dint_off", off, 139);
    check("ab_dint_jobcnt", job_cnt, 8);
    req_dint = 1'b0;
    tick();

    // Reset during RUN, then a tie goes to interleave.
    cfg_pb_len = 12'h040; req_dint = 1'b1;
    wait_start(ok);
    check("rs_start", ok, 1);
    for (int i = 0; i < 5; i++) tick();
    n_rst = 1'b0;
    #1;
    check("rs_busy", busy, 0);
    check("rs_outs", {gnt_int, gnt_dint, itl_start, itl_mod, itl_din_vld, done, err}, 0);
    check("rs_len_cnt", {itl_pb_len, job_cnt}, 0);
    tick();
    n_rst = 1'b1; req_int = 1'b1;
    wait_start(ok);
    check("rs_tie_start", ok, 1);
    check("rs_tie_mod", {itl_mod, gnt_int}, 2'b01);
    req_int = 1'b0; req_dint = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
